pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the MIPS core, generalising the fixed IF/ID and ID/EX registers into one block carrying an arbitrary-width payload plus PC. Adds a valid/ready handshake so stages can stall independently, a synchronous flush that squashes the held instruction to a zeroed bubble, and an optional two-entry skid buffer that cuts the combinational ready path. One instance sits between each pair of adjacent stages (IF→ID, ID→EX, EX→MEM, MEM→WB).

---
 rtl/pipe_stage_reg.sv | 93 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready inter-stage pipeline register with synchronous flush.
// Define PIPE_SKID_EN to add a skid entry that registers in_ready (capacity 2).
module pipe_stage_reg #(
    parameter int WIDTH = 64,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [WIDTH-1:0] out_data
);
    logic             m_valid;
    logic [PC_W-1:0]  m_pc;
    logic [WIDTH-1:0] m_data;
    logic             in_xfer;
    logic             out_xfer;

    assign out_valid = m_valid;
    assign out_pc    = m_pc;
    assign out_data  = m_data;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = m_valid && out_ready;

`ifdef PIPE_SKID_EN
    logic             s_valid;
    logic [PC_W-1:0]  s_pc;
    logic [WIDTH-1:0] s_data;

    assign in_ready = !s_valid;

    // S only fills when M is stuck, so draining S into M preserves beat order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_pc    <= '0;
            s_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_pc    <= '0;
            s_data  <= '0;
        end else if (s_valid) begin
            if (out_xfer) begin
                m_pc    <= s_pc;
                m_data  <= s_data;
                s_valid <= 1'b0;
            end
        end else if (in_xfer && m_valid && !out_ready) begin
            s_valid <= 1'b1;
            s_pc    <= in_pc;
            s_data  <= in_data;
        end else if (in_xfer) begin
            m_valid <= 1'b1;
            m_pc    <= in_pc;
            m_data  <= in_data;
        end else if (out_xfer) begin
            m_valid <= 1'b0;
        end
    end
`else
    assign in_ready = !m_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_data  <= '0;
        end else if (in_xfer) begin
            m_valid <= 1'b1;
            m_pc    <= in_pc;
            m_data  <= in_data;
        end else if (out_xfer) begin
            m_valid <= 1'b0;
        end
    end
`endif
endmodule
